// File: rtl/sample_decimator.sv
// sample_decimator: 2:1 decimating averager with a start/done output handshake.
// Define SAMPLE_DECIMATOR_FIR4_EN for a 4-tap average; the default build uses 2 taps.
module sample_decimator #(
    parameter int IN_WIDTH  = 18,
    parameter int OUT_WIDTH = 12
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        ready,
    input  logic signed [IN_WIDTH-1:0]  incoming_sample,
    input  logic                        done,
    output logic signed [OUT_WIDTH-1:0] outgoing_sample,
    output logic                        start,
    output logic                        overrun
);
`ifdef SAMPLE_DECIMATOR_FIR4_EN
    localparam int TAPS  = 4;
    localparam int SHIFT = 2;
`else
    localparam int TAPS  = 2;
    localparam int SHIFT = 1;
`endif
    localparam int HIST = TAPS - 1;
    localparam int SW   = IN_WIDTH + 2;

    typedef enum logic [1:0] {OUT_IDLE, OUT_START, OUT_GUARD, OUT_WAIT} out_state_e;

    out_state_e                     state_q, state_d;
    logic [HIST-1:0][IN_WIDTH-1:0]  history_q, history_d;
    logic                           phase_q, phase_d;
    logic                           guard_q, guard_d;
    logic                           result_valid_q, result_valid_d;
    logic signed [OUT_WIDTH-1:0]    result_q, result_d;
    logic signed [OUT_WIDTH-1:0]    pending_q, pending_d;
    logic                           pending_valid_q, pending_valid_d;
    logic signed [OUT_WIDTH-1:0]    outgoing_q, outgoing_d;
    logic                           overrun_q, overrun_d;
    logic signed [SW-1:0]           sum;
    logic                           consume;

    always_comb begin
        sum = SW'(incoming_sample);
        for (int i = 0; i < HIST; i++) sum = sum + SW'(signed'(history_q[i]));
        history_d = history_q;
        if (ready) begin
            history_d[0] = incoming_sample;
            for (int i = 1; i < HIST; i++) history_d[i] = history_q[i-1];
        end
        phase_d = phase_q ^ ready;
        result_valid_d = ready & phase_q;
        // Averaging shift and output-bit selection folded into one arithmetic shift.
        result_d = OUT_WIDTH'(sum >>> (SHIFT + IN_WIDTH - OUT_WIDTH));
        // A result landing on the idle cycle bypasses pending and wins over any older one.
        consume = (state_q == OUT_IDLE) && (result_valid_q || pending_valid_q);
        pending_d = result_valid_q ? result_q : pending_q;
        pending_valid_d = consume ? 1'b0 : (pending_valid_q | result_valid_q);
        overrun_d = overrun_q | (result_valid_q & pending_valid_q & ~consume);
        outgoing_d = outgoing_q;
        state_d = state_q;
        guard_d = 1'b0;
        case (state_q)
            OUT_IDLE: if (consume) begin
                outgoing_d = result_valid_q ? result_q : pending_q;
                state_d = OUT_START;
            end
            OUT_START: state_d = OUT_GUARD;
            OUT_GUARD: begin
                guard_d = ~guard_q;
                state_d = guard_q ? OUT_WAIT : OUT_GUARD;
            end
            OUT_WAIT: state_d = done ? OUT_IDLE : OUT_WAIT;
            default: state_d = OUT_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= OUT_IDLE;
            history_q       <= '0;
            phase_q         <= 1'b0;
            guard_q         <= 1'b0;
            result_valid_q  <= 1'b0;
            result_q        <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            outgoing_q      <= '0;
            overrun_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            history_q       <= history_d;
            phase_q         <= phase_d;
            guard_q         <= guard_d;
            result_valid_q  <= result_valid_d;
            result_q        <= result_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            outgoing_q      <= outgoing_d;
            overrun_q       <= overrun_d;
        end
    end

    assign outgoing_sample = outgoing_q;
    assign start           = state_q == OUT_START;
    assign overrun         = overrun_q;
endmodule

// File: doc/sample_decimator.md
SAMPLE_DECIMATOR -- requirements
Module: sample_decimator

Interface
REQ-001 The block SHALL have parameter IN_WIDTH, default 18, meaning signed codec sample width.
REQ-002 The block SHALL have parameter OUT_WIDTH, default 12, meaning signed output sample width.
REQ-003 The block SHALL have port clock, input, 1, the single system clock for all logic.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port ready, input, 1, a one-cycle strobe marking a new 48 kHz codec sample.
REQ-006 The block SHALL have port incoming_sample, input, IN_WIDTH, a signed codec sample valid while ready is high.
REQ-007 The block SHALL have port done, input, 1, the level from the downstream delay stage, high when that stage is idle.
REQ-008 The block SHALL have port outgoing_sample, output, OUT_WIDTH, a signed 24 kHz sample held stable from start until the next start.
REQ-009 The block SHALL have port start, output, 1, a one-cycle strobe telling downstream that outgoing_sample is new.
REQ-010 The block SHALL have port overrun, output, 1, a sticky flag set when a pending output is overwritten.

Function
REQ-011 Every ready strobe SHALL capture incoming_sample into a history register, regardless of output handshake state.
REQ-012 A 1-bit phase counter SHALL toggle on each ready; a decimated result SHALL be produced only on captures where phase was 1, i.e. every second input.
REQ-013 Filter sum SHALL use IN_WIDTH+2 signed bits: the average is the sum arithmetic-shifted right by log2(taps), and the output is average bits [IN_WIDTH-1 : IN_WIDTH-OUT_WIDTH] (truncation toward minus infinity, no saturation needed).
REQ-014 The result SHALL be registered into a 1-deep pending register on the cycle after the capturing ready, setting pending_valid.
REQ-015 The output FSM SHALL have states OUT_IDLE, OUT_START, OUT_GUARD and OUT_WAIT.
REQ-016 In OUT_IDLE with pending_valid, the FSM SHALL copy pending to outgoing_sample, clear pending_valid and go to OUT_START.
REQ-017 OUT_START SHALL assert start for exactly one cycle and go to OUT_GUARD.
REQ-018 OUT_GUARD SHALL last 2 cycles and ignore done, covering downstream's one-cycle lag in lowering done; it then goes to OUT_WAIT.
REQ-019 OUT_WAIT SHALL return to OUT_IDLE on the first cycle with done high.
REQ-020 Latency from the ready that completes a pair to start high, with the FSM idle, SHALL be 2 cycles.
REQ-021 If a new result arrives while pending_valid is already set, it SHALL overwrite pending and set overrun; overrun SHALL clear only on reset.
REQ-022 If pending_valid is set in the same cycle that OUT_IDLE consumes it, the FSM SHALL consume the new value, with no overrun.
REQ-023 A ready strobe in any FSM state SHALL NOT disturb outgoing_sample, which changes only on leaving OUT_IDLE.
REQ-024 When done is tied high, as with downstream disabled, the handshake SHALL complete in 4 cycles with no overrun at one start per 2 ready strobes spaced 4 or more cycles apart.

Reset
REQ-025 Reset SHALL be synchronous and active-high: outgoing_sample=0, start=0, overrun=0, phase=0, history=0, pending=0, pending_valid=0, FSM=OUT_IDLE.
REQ-026 Reset asserted mid-handshake SHALL abort the handshake and drop any pending sample; start SHALL NOT assert during or in the cycle after reset.
REQ-027 Reset SHALL take priority over a ready strobe in the same cycle.

Configuration
REQ-028 With macro SAMPLE_DECIMATOR_FIR4_EN defined, the filter SHALL average the 4 most recent inputs (shift 2), using a 3-entry history.
REQ-029 Without SAMPLE_DECIMATOR_FIR4_EN, the filter SHALL average the 2 most recent inputs (shift 1), using a 1-entry history; all other behaviour is identical.

Verification
REQ-030 Without FIR4, inputs 1024 then 3072, done tied high -> one start 2 cycles after the second ready, outgoing_sample = (2048)>>6 = 32.
REQ-031 Without FIR4, inputs -64 then -64 -> outgoing_sample = -1, which checks arithmetic truncation.
REQ-032 With FIR4, after reset, inputs 4096 x4 -> first output = 2048>>6 = 32, second output = 4096>>6 = 64.
REQ-033 Done held low for 20 cycles after start while 4 further ready strobes arrive -> exactly one further start after done rises, carrying the latest pair, and overrun = 1.
REQ-034 Reset asserted in OUT_GUARD with pending_valid set -> start, overrun and outgoing_sample = 0, and no start until 2 new inputs arrive.
